// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Purpose  : 640x480 @ 60 Hz VGA raster timing from the 100 MHz board clock.
//             Divides the board clock down to a pixel-enable, runs the
//             horizontal/vertical pixel counters and decodes the active-low
//             sync pulses and the visible-window flag.
//  Ports    : clk             - board clock, all state on the rising edge
//             rst_n           - asynchronous, active-low reset
//             H_Counter_Value - horizontal pixel position, 0..H_TOTAL-1
//             V_Counter_Value - vertical line position, 0..V_TOTAL-1
//             Hsync / Vsync   - active-low sync pulses
//             Pixel_Tick      - one-clk pulse; counters advance on the next edge
//             Video_On        - counters address the visible window
//             Frame_Start     - one-clk pulse when the counters wrap to (0,0)
//  Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 800,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] H_Counter_Value,
    output logic [15:0] V_Counter_Value,
    output logic        Hsync,
    output logic        Vsync,
    output logic        Pixel_Tick,
    output logic        Video_On,
    output logic        Frame_Start
);

    // A divide-by-one build still needs a 1-bit divider register.
    localparam int                 c_DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST   = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_ONE    = c_DIV_W'(1);

    localparam logic [15:0] c_H_LAST      = 16'(H_TOTAL - 1);
    localparam logic [15:0] c_V_LAST      = 16'(V_TOTAL - 1);
    localparam logic [15:0] c_H_SYNC      = 16'(H_SYNC);
    localparam logic [15:0] c_V_SYNC      = 16'(V_SYNC);
    localparam logic [15:0] c_H_VIS_START = 16'(H_SYNC + H_BP);
    localparam logic [15:0] c_H_VIS_END   = 16'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [15:0] c_V_VIS_START = 16'(V_SYNC + V_BP);
    localparam logic [15:0] c_V_VIS_END   = 16'(V_SYNC + V_BP + V_ACTIVE);

    logic [c_DIV_W-1:0] r_div;
    logic               r_tick;
    logic [15:0]        r_h;
    logic [15:0]        r_v;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_video_on;
    logic               r_frame_start;

    logic [15:0]        w_h_next;
    logic [15:0]        w_v_next;
    logic               w_frame_wrap;
    logic               w_hsync;
    logic               w_vsync;
    logic               w_video_on;

    // Next-state counters: only move in the cycle where the registered tick is high.
    always_comb begin
        w_h_next = r_h;
        w_v_next = r_v;
        if (r_tick) begin
            if (r_h == c_H_LAST) begin
                w_h_next = '0;
                if (r_v == c_V_LAST) begin
                    w_v_next = '0;
                end else begin
                    w_v_next = r_v + 16'd1;
                end
            end else begin
                w_h_next = r_h + 16'd1;
            end
        end
    end

    assign w_frame_wrap = r_tick && (r_h == c_H_LAST) && (r_v == c_V_LAST);

    // Decode from the next-state counters so the registered flags line up
    // with the registered counter values on the same edge.
    assign w_hsync    = (w_h_next >= c_H_SYNC);
    assign w_vsync    = (w_v_next >= c_V_SYNC);
    assign w_video_on = (w_h_next >= c_H_VIS_START) && (w_h_next < c_H_VIS_END) &&
                        (w_v_next >= c_V_VIS_START) && (w_v_next < c_V_VIS_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div         <= '0;
            r_tick        <= 1'b0;
            r_h           <= '0;
            r_v           <= '0;
            r_hsync       <= 1'b0;
            r_vsync       <= 1'b0;
            r_video_on    <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_div         <= (r_div == c_DIV_LAST) ? '0 : r_div + c_DIV_ONE;
            // Registering the terminal-count compare puts the first tick
            // exactly CLK_DIV edges after reset release.
            r_tick        <= (r_div == c_DIV_LAST);
            r_h           <= w_h_next;
            r_v           <= w_v_next;
            r_hsync       <= w_hsync;
            r_vsync       <= w_vsync;
            r_video_on    <= w_video_on;
            r_frame_start <= w_frame_wrap;
        end
    end

    assign H_Counter_Value = r_h;
    assign V_Counter_Value = r_v;
    assign Hsync           = r_hsync;
    assign Vsync           = r_vsync;
    assign Pixel_Tick      = r_tick;
    assign Video_On        = r_video_on;
    assign Frame_Start     = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_gen
//  Purpose  : Self-checking bench for vga_timing_gen. Three builds run side
//             by side: default 640x480 timing, a small raster with a
//             divide-by-3 pixel clock, and the same small raster divided by 1.
//             Expected outputs come from an elapsed-clock raster model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    typedef struct {
        int cd, hs, hb, ha, ht, vs, vb, va, vt;
    } geom_t;

    function automatic geom_t geom(int i);
        geom_t g;
        case (i)
            0:       g = '{4, 96, 48, 640, 800, 2, 33, 480, 525};
            1:       g = '{3, 5, 3, 16, 30, 2, 3, 8, 16};
            default: g = '{1, 5, 3, 16, 30, 2, 3, 8, 16};
        endcase
        return g;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rn0 = 1'b0, rn1 = 1'b0, rn2 = 1'b0;
    logic [15:0] h0, v0, h1, v1, h2, v2;
    logic hsy0, vsy0, pt0, vo0, fs0;
    logic hsy1, vsy1, pt1, vo1, fs1;
    logic hsy2, vsy2, pt2, vo2, fs2;
    longint k0 = 0, k1 = 0, k2 = 0;   // clock edges seen since reset release
    int n_checks = 0;
    int n_fail   = 0;

    vga_timing_gen u_dut0 (
        .clk(clk), .rst_n(rn0), .H_Counter_Value(h0), .V_Counter_Value(v0),
        .Hsync(hsy0), .Vsync(vsy0), .Pixel_Tick(pt0), .Video_On(vo0), .Frame_Start(fs0)
    );

    vga_timing_gen #(
        .CLK_DIV(3), .H_SYNC(5), .H_BP(3), .H_ACTIVE(16), .H_TOTAL(30),
        .V_SYNC(2), .V_BP(3), .V_ACTIVE(8), .V_TOTAL(16)
    ) u_dut1 (
        .clk(clk), .rst_n(rn1), .H_Counter_Value(h1), .V_Counter_Value(v1),
        .Hsync(hsy1), .Vsync(vsy1), .Pixel_Tick(pt1), .Video_On(vo1), .Frame_Start(fs1)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_SYNC(5), .H_BP(3), .H_ACTIVE(16), .H_TOTAL(30),
        .V_SYNC(2), .V_BP(3), .V_ACTIVE(8), .V_TOTAL(16)
    ) u_dut2 (
        .clk(clk), .rst_n(rn2), .H_Counter_Value(h2), .V_Counter_Value(v2),
        .Hsync(hsy2), .Vsync(vsy2), .Pixel_Tick(pt2), .Video_On(vo2), .Frame_Start(fs2)
    );

    always @(posedge clk or negedge rn0) if (!rn0) k0 <= 0; else k0 <= k0 + 1;
    always @(posedge clk or negedge rn1) if (!rn1) k1 <= 0; else k1 <= k1 + 1;
    always @(posedge clk or negedge rn2) if (!rn2) k2 <= 0; else k2 <= k2 + 1;

    function automatic longint kof(int i);
        case (i)
            0:       return k0;
            1:       return k1;
            default: return k2;
        endcase
    endfunction

    function automatic logic [36:0] obs(int i);
        case (i)
            0:       return {h0, v0, hsy0, vsy0, pt0, vo0, fs0};
            1:       return {h1, v1, hsy1, vsy1, pt1, vo1, fs1};
            default: return {h2, v2, hsy2, vsy2, pt2, vo2, fs2};
        endcase
    endfunction

    task automatic set_rst(int i, logic val);
        case (i)
            0:       rn0 = val;
            1:       rn1 = val;
            default: rn2 = val;
        endcase
    endtask

    // Raster model: after kk edges, the pixel count is the number of ticks
    // that have been consumed; position is that count modulo the frame size.
    function automatic logic [36:0] model(int i, longint kk);
        geom_t  g;
        longint adv, p, h, v;
        logic   tick, fs, hs, vs, vid;
        g    = geom(i);
        adv  = (kk >= 1) ? (kk - 1) / g.cd : 0;
        p    = adv % (g.ht * g.vt);
        h    = p % g.ht;
        v    = p / g.ht;
        tick = (kk >= g.cd) && (kk % g.cd == 0);
        fs   = (kk - 1 >= g.cd) && ((kk - 1) % g.cd == 0) && (p == 0);
        hs   = (h >= g.hs);
        vs   = (v >= g.vs);
        vid  = (h >= g.hs + g.hb) && (h < g.hs + g.hb + g.ha) &&
               (v >= g.vs + g.vb) && (v < g.vs + g.vb + g.va);
        return {h[15:0], v[15:0], hs, vs, tick, vid, fs};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [36:0] act, exp;
        rn0 = 1'b0; rn1 = 1'b0; rn2 = 1'b0;
        repeat (3) step();
        for (int i = 0; i < 3; i++) begin
            act = obs(i);
            n_checks++;
            if (act !== 37'h0) begin
                n_fail++;
                $display("FAIL reset_values dut%0d: got %h expected %h", i, act, 37'h0);
            end
        end
        @(negedge clk);
        rn0 = 1'b1; rn1 = 1'b1; rn2 = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            step();
            n_checks++;
            if (pt0 !== ((e % 4) == 0)) begin
                n_fail++;
                $display("FAIL first_tick edge%0d: got %b expected %b", e, pt0, (e % 4) == 0);
            end
            for (int i = 0; i < 3; i++) begin
                act = obs(i);
                exp = model(i, kof(i));
                n_checks++;
                if (act !== exp) begin
                    n_fail++;
                    $display("FAIL after_reset dut%0d k=%0d: got %h expected %h", i, kof(i), act, exp);
                end
            end
        end
    endtask

    task automatic test_line_wrap();
        logic [36:0] act, exp;
        logic [15:0] ph, pv;
        logic        phs, saw_wrap, saw_fall;
        int          low_len;
        longint      target;
        target   = longint'(11 * 800 + 110) * 4;
        ph = h0; pv = v0; phs = hsy0;
        saw_wrap = 1'b0; saw_fall = 1'b0; low_len = 0;
        while (k0 < target) begin
            step();
            for (int i = 0; i < 3; i++) begin
                act = obs(i);
                exp = model(i, kof(i));
                n_checks++;
                if (act !== exp) begin
                    n_fail++;
                    if (n_fail < 40) $display("FAIL raster dut%0d k=%0d: got %h expected %h", i, kof(i), act, exp);
                end
            end
            if (ph == 16'd799 && pv == 16'd10 && h0 != 16'd799) begin
                saw_wrap = 1'b1;
                n_checks++;
                if ({h0, v0, hsy0} !== {16'd0, 16'd11, 1'b0}) begin
                    n_fail++;
                    $display("FAIL line_wrap: got H=%0d V=%0d Hsync=%b expected H=0 V=11 Hsync=0", h0, v0, hsy0);
                end
            end
            if (phs && !hsy0) begin
                saw_fall = 1'b1;
                low_len  = 0;
            end
            if (!hsy0) low_len++;
            if (!phs && hsy0 && saw_fall) begin
                n_checks++;
                if (low_len != 384 || h0 != 16'd96) begin
                    n_fail++;
                    $display("FAIL hsync_width: got %0d clk ending at H=%0d expected 384 clk ending at H=96", low_len, h0);
                end
            end
            ph = h0; pv = v0; phs = hsy0;
        end
        n_checks++;
        if (!saw_wrap) begin
            n_fail++;
            $display("FAIL line_wrap_seen: got none expected wrap from (799,10)");
        end
    endtask

    task automatic test_frame_and_window();
        logic [36:0] act, exp;
        logic        pvo;
        int          seen, vo_cnt, guard;
        longint      t_prev;
        seen = 0; vo_cnt = 0; guard = 0; t_prev = 0; pvo = vo1;
        while (seen < 3 && guard < 3 * 1440 + 20) begin
            step();
            guard++;
            act = obs(1);
            exp = model(1, k1);
            n_checks++;
            if (act !== exp) begin
                n_fail++;
                if (n_fail < 40) $display("FAIL frame_raster k=%0d: got %h expected %h", k1, act, exp);
            end
            if (seen == 1 && vo1) vo_cnt++;
            if (vo1 && !pvo) begin
                n_checks++;
                if (h1 != 16'd8) begin
                    n_fail++;
                    $display("FAIL video_rise: got H=%0d expected H=8", h1);
                end
            end
            if (!vo1 && pvo) begin
                n_checks++;
                if (h1 != 16'd24) begin
                    n_fail++;
                    $display("FAIL video_fall: got H=%0d expected H=24", h1);
                end
            end
            pvo = vo1;
            if (fs1) begin
                n_checks++;
                if ({h1, v1, vsy1} !== {16'd0, 16'd0, 1'b0}) begin
                    n_fail++;
                    $display("FAIL frame_start_pos: got H=%0d V=%0d Vsync=%b expected 0 0 0", h1, v1, vsy1);
                end
                if (seen >= 1) begin
                    n_checks++;
                    if (k1 - t_prev != 1440) begin
                        n_fail++;
                        $display("FAIL frame_period: got %0d expected 1440", k1 - t_prev);
                    end
                end
                t_prev = k1;
                seen++;
            end
        end
        n_checks++;
        if (seen < 3) begin
            n_fail++;
            $display("FAIL frame_timeout: got %0d pulses expected 3", seen);
        end
        n_checks++;
        if (vo_cnt != 16 * 8 * 3) begin
            n_fail++;
            $display("FAIL video_count: got %0d expected %0d", vo_cnt, 16 * 8 * 3);
        end
    endtask

    task automatic test_div1();
        logic [36:0] act, exp;
        int          seen;
        longint      t_prev;
        seen = 0; t_prev = 0;
        for (int c = 0; c < 2 * 480 + 20; c++) begin
            step();
            act = obs(2);
            exp = model(2, k2);
            n_checks++;
            if (act !== exp || pt2 !== 1'b1) begin
                n_fail++;
                if (n_fail < 40) $display("FAIL div1_raster k=%0d: got %h expected %h", k2, act, exp);
            end
            if (fs2) begin
                if (seen >= 1) begin
                    n_checks++;
                    if (k2 - t_prev != 480) begin
                        n_fail++;
                        $display("FAIL div1_frame_period: got %0d expected 480", k2 - t_prev);
                    end
                end
                t_prev = k2;
                seen++;
            end
        end
        n_checks++;
        if (seen < 2) begin
            n_fail++;
            $display("FAIL div1_frames: got %0d pulses expected at least 2", seen);
        end
    endtask

    task automatic test_reset_mid();
        logic [36:0] act, exp;
        int          i, n, d;
        for (int rep = 0; rep < 6; rep++) begin
            i = (rep < 3) ? rep : int'($urandom_range(0, 2));
            n = int'($urandom_range(50, 2000));
            repeat (n) begin
                step();
                act = obs(i);
                exp = model(i, kof(i));
                n_checks++;
                if (act !== exp) begin
                    n_fail++;
                    if (n_fail < 40) $display("FAIL pre_reset dut%0d k=%0d: got %h expected %h", i, kof(i), act, exp);
                end
            end
            d = int'($urandom_range(1, 7));
            #(d);
            set_rst(i, 1'b0);
            #1;
            act = obs(i);
            n_checks++;
            if (act !== 37'h0) begin
                n_fail++;
                $display("FAIL async_reset dut%0d: got %h expected %h", i, act, 37'h0);
            end
            repeat (2) @(posedge clk);
            @(negedge clk);
            set_rst(i, 1'b1);
            for (int c = 0; c < 3 * geom(i).cd + 5; c++) begin
                step();
                act = obs(i);
                exp = model(i, kof(i));
                n_checks++;
                if (act !== exp || act[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL restart dut%0d k=%0d: got %h expected %h", i, kof(i), act, exp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_line_wrap();
        test_frame_and_window();
        test_div1();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
